ssd_code_driver: RTL and testbench
==================================

SSD_CODE_DRIVER -- requirements
Module: ssd_code_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clk cycles each digit stays selected (legal range 2..2^20).
REQ-002 Parameter OVF_CODE, default 5'd31, code emitted on every digit for numeric overflow (decoder renders "-").
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 load  input  1  one-cycle request to capture new display content.
REQ-006 mode  input  1  0 = numeric (value), 1 = text (text).
REQ-007 value  input  14  unsigned binary number to show in decimal.
REQ-008 text  input  20  four 5-bit display codes; [4:0] = digit 0 (rightmost), [19:15] = digit 3.
REQ-009 code  output  5  display code of the selected digit, feeds the BCD/letter-to-segment decoder.
REQ-010 an  output  4  active-low digit enables; exactly one bit low at any time after reset.
REQ-011 busy  output  1  high while a capture/conversion is in progress.

Function
REQ-012 Control FSM SHALL have states IDLE, SHIFT, COMMIT; reset state IDLE.
REQ-013 In IDLE, load=1 SHALL capture mode, value and text into internal registers on that edge and set busy=1 on the next cycle.
REQ-014 From IDLE with captured mode=1, FSM SHALL go directly to COMMIT (busy high for exactly 1 cycle).
REQ-015 From IDLE with captured mode=0 and value <= 9999, FSM SHALL enter SHIFT and run a sequential shift-add-3 binary-to-BCD conversion, one value bit per cycle, MSB first, exactly 14 SHIFT cycles, then COMMIT (busy high for 15 cycles).
REQ-016 Before each shift, every 4-bit BCD nibble >= 5 SHALL have 3 added; four nibbles (16 bits) SHALL hold the result; no nibble may exceed 9 after the final shift.
REQ-017 With captured mode=0 and value > 9999, FSM SHALL go directly to COMMIT and load OVF_CODE into all four digit registers.
REQ-018 In COMMIT the four 5-bit digit registers SHALL update atomically (numeric: {1'b0, nibble}; text: the captured fields), then FSM returns to IDLE and busy drops on the next cycle.
REQ-019 Leading zeros SHALL be displayed as code 0 (no blanking).
REQ-020 load asserted while busy=1 SHALL be ignored; no queuing.
REQ-021 Digit registers SHALL keep the previous content throughout SHIFT; displayed content never shows partial conversions.
REQ-022 A prescale counter SHALL count 0..REFRESH_DIV-1 continuously, independent of the FSM; on terminal count it wraps to 0 and the digit index increments.
REQ-023 Digit index SHALL be 2 bits and wrap 3 -> 0.
REQ-024 an SHALL equal the bitwise inverse of (1 << index); code SHALL equal digit register[index]; both registered, changing on the same edge.
REQ-025 A COMMIT coinciding with a digit advance SHALL show the new content on the newly selected digit in the next cycle.

Reset
REQ-026 While rst=0: state IDLE, busy=0, all digit registers 0, prescaler 0, index 0, an=4'b1110, code=5'd0, conversion registers 0.
REQ-027 Reset asserted mid-SHIFT SHALL abort the conversion; after release the block is in IDLE with digits 0 and accepts load on the first edge.
REQ-028 Outputs SHALL reach reset values asynchronously, without a clk edge.

Verification
REQ-029 Reset release, no load, REFRESH_DIV=4 -> an cycles 1110,1101,1011,0111,1110 every 4 clks, code=0 throughout.
REQ-030 load, mode=0, value=1234 -> busy high 15 cycles; afterwards digit0..3 codes = 4,3,2,1.
REQ-031 load, mode=0, value=9999 then value=10000 -> codes 9,9,9,9 then 31,31,31,31 (busy 1 cycle for overflow).
REQ-032 load, mode=1, text={5'd10,5'd23,5'd14,5'd23} -> busy 1 cycle; digits 3..0 show H,A,L,A (codes 10,23,14,23).
REQ-033 load value=42 followed by load value=7 three cycles later -> second load ignored; result 0,0,4,2.
REQ-034 rst pulsed low at SHIFT cycle 7 of value=5678 -> busy=0, an=1110, code=0 immediately; digits remain 0 after release.

Source files
------------

// File: rtl/ssd_code_driver_if.sv
// ssd_code_driver_if: groups the host-side capture handshake and the
// display-side outputs of ssd_code_driver.
//   load  : one-cycle request to capture new display content
//   mode  : 0 = numeric (value), 1 = text (text)
//   value : 14-bit unsigned number shown in decimal
//   text  : four 5-bit codes, [4:0] = digit 0 (rightmost)
//   busy  : capture/conversion in progress
//   code  : display code of the selected digit
//   an    : active-low digit enables
// Modports: master = host/bench side, slave = ssd_code_driver.
interface ssd_code_driver_if;
  logic        load;
  logic        mode;
  logic [13:0] value;
  logic [19:0] text;
  logic        busy;
  logic [4:0]  code;
  logic [3:0]  an;

  modport master (
    output load, mode, value, text,
    input  busy, code, an
  );

  modport slave (
    input  load, mode, value, text,
    output busy, code, an
  );
endinterface

// File: rtl/ssd_code_driver.sv
// ssd_code_driver: captures numeric or text content for a 4-digit
// multiplexed display, converts numbers to BCD with a sequential
// shift-add-3 engine and scans the four digits.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : ssd_code_driver_if.slave (load/mode/value/text in, busy/code/an out)
// Parameters:
//   REFRESH_DIV : clk cycles each digit stays selected (2..2^20)
//   OVF_CODE    : code shown on every digit when value > 9999
module ssd_code_driver #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter logic [4:0]  OVF_CODE    = 5'd31
) (
  input  logic              clk,
  input  logic              rst,
  ssd_code_driver_if.slave  bus
);

  localparam int unsigned PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  state_e      state_q, state_d;
  logic        capture, shift_en, commit;

  logic        mode_q;
  logic        ovf_q;
  logic [13:0] value_q;
  logic [19:0] text_q;
  logic [15:0] bcd_q, bcd_adj;
  logic [3:0]  cnt_q;

  logic [4:0]  digit_q [4];
  logic [4:0]  digit_d [4];

  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q, idx_d;
  logic          presc_wrap;
  logic [3:0]    an_q;
  logic [4:0]    code_q;

  // Control FSM
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    shift_en = 1'b0;
    commit   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.load) begin
          capture = 1'b1;
          // Text and overflow need no conversion
          if (bus.mode || (bus.value > 14'd9999)) state_d = StCommit;
          else                                    state_d = StShift;
        end
      end
      StShift: begin
        shift_en = 1'b1;
        if (cnt_q == 4'd13) state_d = StCommit;
      end
      StCommit: begin
        commit  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Add 3 to every nibble >= 5 before the shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Capture and conversion registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q  <= 1'b0;
      ovf_q   <= 1'b0;
      value_q <= '0;
      text_q  <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else if (capture) begin
      mode_q  <= bus.mode;
      ovf_q   <= !bus.mode && (bus.value > 14'd9999);
      value_q <= bus.value;
      text_q  <= bus.text;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else if (shift_en) begin
      bcd_q   <= {bcd_adj[14:0], value_q[13]};
      value_q <= {value_q[12:0], 1'b0};
      cnt_q   <= cnt_q + 4'd1;
    end
  end

  // Digit registers change only in COMMIT, all four together
  always_comb begin
    digit_d = digit_q;
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (mode_q)     digit_d[i] = text_q[5*i +: 5];
        else if (ovf_q) digit_d[i] = OVF_CODE;
        else            digit_d[i] = {1'b0, bcd_q[4*i +: 4]};
      end
    end
  end

  // Free-running digit scan
  assign presc_wrap = (presc_q == PrescMax);
  assign idx_d      = presc_wrap ? idx_q + 2'd1 : idx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= 4'b1110;
      code_q  <= '0;
      for (int i = 0; i < 4; i++) digit_q[i] <= '0;
    end else begin
      presc_q <= presc_wrap ? '0 : presc_q + PW'(1);
      idx_q   <= idx_d;
      digit_q <= digit_d;
      // Look-ahead on index and digits so a commit landing on a digit
      // advance shows new content on the new digit immediately
      an_q    <= ~(4'b0001 << idx_d);
      code_q  <= digit_d[idx_d];
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.an   = an_q;
  assign bus.code = code_q;

endmodule

// File: tb/tb_ssd_code_driver.sv
// tb_ssd_code_driver: scoreboard bench for ssd_code_driver with
// REFRESH_DIV = 4. Expected digit codes and busy length are pushed when a
// load is driven and popped when busy falls, then the scan is checked.
module tb_ssd_code_driver;

  typedef struct {
    logic [19:0] codes;
    int          busy_len;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [19:0] shown = '0;

  ssd_code_driver_if bus ();

  ssd_code_driver #(
    .REFRESH_DIV (4),
    .OVF_CODE    (5'd31)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic m, input logic [13:0] v, input logic [19:0] t);
    exp_t e;
    int   tmp;
    if (m) begin
      e.codes    = t;
      e.busy_len = 1;
    end else if (v > 14'd9999) begin
      e.codes    = {4{5'd31}};
      e.busy_len = 1;
    end else begin
      tmp = int'(v);
      for (int i = 0; i < 4; i++) begin
        e.codes[5*i +: 5] = 5'(tmp % 10);
        tmp = tmp / 10;
      end
      e.busy_len = 15;
    end
    return e;
  endfunction

  function automatic int an_idx(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return 4;
    endcase
  endfunction

  // Called #1 after a posedge; drives load for exactly one edge
  task automatic start_load(input logic m, input logic [13:0] v, input logic [19:0] t,
                            input bit push);
    bus.load  = 1'b1;
    bus.mode  = m;
    bus.value = v;
    bus.text  = t;
    @(posedge clk); #1;
    bus.load = 1'b0;
    if (push) sb.push_back(model(m, v, t));
  endtask

  task automatic scan();
    logic [3:0] seen;
    int         i;
    seen = '0;
    check("idle_busy", 32'(bus.busy), 32'd0);
    repeat (16) begin
      i = an_idx(bus.an);
      check("an_onehot", 32'(i < 4), 32'd1);
      if (i < 4) begin
        check("code", 32'(bus.code), 32'(shown[5*i +: 5]));
        seen[i] = 1'b1;
      end
      @(posedge clk); #1;
    end
    check("seen_all", 32'(seen), 32'hf);
  endtask

  // Counts busy cycles, checks digits hold old content, optionally
  // drives a second load inj_at cycles after capture
  task automatic finish_txn(input int inj_at, input logic [13:0] inj_val);
    int   cnt;
    int   i;
    exp_t e;
    cnt = 0;
    while (bus.busy && cnt < 64) begin
      i = an_idx(bus.an);
      if (i < 4) check("hold", 32'(bus.code), 32'(shown[5*i +: 5]));
      else       check("an_onehot_busy", 32'(bus.an), 32'he);
      if (cnt == inj_at) begin
        bus.load  = 1'b1;
        bus.value = inj_val;
      end else begin
        bus.load = 1'b0;
      end
      cnt++;
      @(posedge clk); #1;
    end
    bus.load = 1'b0;
    if (cnt >= 64) check("busy_timeout", 32'(cnt), 32'd0);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("busy_len", 32'(cnt), 32'(e.busy_len));
      shown = e.codes;
      scan();
    end
  endtask

  initial begin
    logic [3:0]  ea;
    logic [13:0] rv;
    bus.load  = 1'b0;
    bus.mode  = 1'b0;
    bus.value = '0;
    bus.text  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_an", 32'(bus.an), 32'he);
    check("rst_code", 32'(bus.code), 32'd0);
    rst = 1'b1;

    // Idle scan after release
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk); #1;
      ea = ~(4'b0001 << ((k / 4) % 4));
      check("an_seq", 32'(bus.an), 32'(ea));
      check("an_code0", 32'(bus.code), 32'd0);
    end

    start_load(1'b0, 14'd1234, 20'd0, 1'b1);  finish_txn(-1, 14'd0);
    start_load(1'b0, 14'd9999, 20'd0, 1'b1);  finish_txn(-1, 14'd0);
    start_load(1'b0, 14'd10000, 20'd0, 1'b1); finish_txn(-1, 14'd0);
    start_load(1'b1, 14'd0, {5'd10, 5'd23, 5'd14, 5'd23}, 1'b1); finish_txn(-1, 14'd0);
    // Second load three cycles after the first is ignored
    start_load(1'b0, 14'd42, 20'd0, 1'b1);    finish_txn(2, 14'd7);
    start_load(1'b0, 14'd0, 20'd0, 1'b1);     finish_txn(-1, 14'd0);
    start_load(1'b0, 14'd16383, 20'd0, 1'b1); finish_txn(-1, 14'd0);
    start_load(1'b0, 14'd8888, 20'd0, 1'b1);  finish_txn(-1, 14'd0);
    for (int n = 0; n < 4; n++) begin
      rv = 14'($urandom_range(0, 16383));
      start_load(1'(n % 2), rv, 20'($urandom), 1'b1);
      finish_txn(-1, 14'd0);
    end

    // Reset in the middle of a conversion
    start_load(1'b0, 14'd5678, 20'd0, 1'b0);
    repeat (6) begin
      @(posedge clk); #1;
    end
    check("mid_shift_busy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_busy", 32'(bus.busy), 32'd0);
    check("async_an", 32'(bus.an), 32'he);
    check("async_code", 32'(bus.code), 32'd0);
    @(posedge clk); #1;
    rst   = 1'b1;
    shown = '0;
    scan();

    // Load accepted on the first edge after release
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    start_load(1'b1, 14'd0, {5'd1, 5'd2, 5'd3, 5'd4}, 1'b1);
    finish_txn(-1, 14'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
